// File: rtl/ssd_scroll_scheduler.sv
// Scrolls a message of up to 16 characters across a 4-digit active-low seven-segment display.
// Optional macro SSD_SCROLL_DIR_EN adds a 'dir' input that selects backward scrolling.
module ssd_scroll_scheduler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned SCROLL_DIV  = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SWT,
`ifdef SSD_SCROLL_DIR_EN
    input  logic       dir,
`endif
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_char,
    input  logic       start,
    input  logic       stop,
    input  logic [4:0] msg_len,
    output logic       busy,
    output logic [3:0] anode,
    output logic [6:0] segOut
);
    localparam int unsigned RW        = $clog2(REFRESH_DIV);
    localparam int unsigned SW        = $clog2(SCROLL_DIV);
    localparam int unsigned DEPTH     = 16;
    localparam logic [4:0]  MAX_LEN   = 5'd16;
    localparam logic [4:0]  BLANK     = 5'd31;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    char_buf [DEPTH];
    logic [3:0]    pos_q, pos_d;
    logic [4:0]    len_q, len_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [RW-1:0] rcnt_q;
    logic [1:0]    d_q;

    logic          start_ok_c;
    logic [4:0]    len_clamp_c;
    logic [3:0]    pos_fwd_c;
    logic [3:0]    pos_step_c;
    logic [1:0]    slot_c;
    logic [4:0]    sum_c;
    logic [4:0]    idx_c;
    logic [4:0]    code_c;
    logic [6:0]    seg_c;

    assign start_ok_c  = start && (msg_len != 5'd0);
    assign len_clamp_c = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
    assign pos_fwd_c   = ({1'b0, pos_q} == (len_q - 5'd1)) ? 4'd0 : pos_q + 4'd1;

`ifdef SSD_SCROLL_DIR_EN
    assign pos_step_c  = dir ? ((pos_q == 4'd0) ? 4'(len_q - 5'd1) : pos_q - 4'd1) : pos_fwd_c;
`else
    assign pos_step_c  = pos_fwd_c;
`endif

    // Character slot within the window: d=3 is slot 0 (leftmost).
    assign slot_c = ~d_q;
    assign sum_c  = {1'b0, pos_q} + {3'b000, slot_c};
    assign idx_c  = ((len_q > 5'd4) && (sum_c >= len_q)) ? sum_c - len_q : sum_c;

    always_comb begin
        code_c = char_buf[idx_c[3:0]];
        if ((len_q <= 5'd4) && ({3'b000, slot_c} >= len_q)) begin
            code_c = BLANK;
        end
    end

    always_comb begin
        seg_c = SEG_BLANK;
        case (code_c)
            5'd0:  seg_c = 7'b1000000;
            5'd1:  seg_c = 7'b1111001;
            5'd2:  seg_c = 7'b0100100;
            5'd3:  seg_c = 7'b0110000;
            5'd4:  seg_c = 7'b0011001;
            5'd5:  seg_c = 7'b0010010;
            5'd6:  seg_c = 7'b0000010;
            5'd7:  seg_c = 7'b1111000;
            5'd8:  seg_c = 7'b0000000;
            5'd9:  seg_c = 7'b0010000;
            5'd10: seg_c = 7'b0001000;
            5'd11: seg_c = 7'b0000011;
            5'd12: seg_c = 7'b1000110;
            5'd13: seg_c = 7'b0100001;
            5'd14: seg_c = 7'b0000110;
            5'd15: seg_c = 7'b0001110;
            5'd16: seg_c = 7'b0111111;
            default: seg_c = SEG_BLANK;
        endcase
    end

    // Next state: stop beats start; scrolling only advances in RUN with a long message.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        scnt_d  = scnt_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start_ok_c) begin
            state_d = RUN;
            pos_d   = 4'd0;
            scnt_d  = '0;
            len_d   = len_clamp_c;
        end else if ((state_q == RUN) && SWT && (len_q > 5'd4)) begin
            if (scnt_q == SW'(SCROLL_DIV - 1)) begin
                scnt_d = '0;
                pos_d  = pos_step_c;
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= 4'd0;
            len_q   <= 5'd0;
            scnt_q  <= '0;
            rcnt_q  <= '0;
            d_q     <= 2'd0;
            busy    <= 1'b0;
            anode   <= 4'b1111;
            segOut  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            scnt_q  <= scnt_d;
            busy    <= (state_d == RUN);
            if (SWT) begin
                if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
                    rcnt_q <= '0;
                    d_q    <= d_q - 2'd1;
                end else begin
                    rcnt_q <= rcnt_q + RW'(1);
                end
                anode  <= ~(4'b0001 << d_q);
                segOut <= (state_q == RUN) ? seg_c : SEG_BLANK;
            end else begin
                anode  <= 4'b1111;
                segOut <= SEG_BLANK;
            end
        end
    end

    // Message buffer is host-owned and intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            char_buf[wr_addr] <= wr_char;
        end
    end
endmodule

// File: tb/tb_ssd_scroll_scheduler.sv
// Bench for ssd_scroll_scheduler: directed steps plus random traffic against a window/scroll reference model.
module tb_ssd_scroll_scheduler;
    localparam int unsigned RDIV = 4;
    localparam int unsigned SDIV = 32;
    localparam logic [6:0] GLYPH [17] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F};

    logic       clk = 1'b0;
    logic       rst, SWT, dir, wr_en, start, stop;
    logic [3:0] wr_addr;
    logic [4:0] wr_char, msg_len;
    logic       busy;
    logic [3:0] anode;
    logic [6:0] segOut;

    always #5 clk = ~clk;

    ssd_scroll_scheduler #(.REFRESH_DIV(RDIV), .SCROLL_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .SWT(SWT),
`ifdef SSD_SCROLL_DIR_EN
        .dir(dir),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .start(start), .stop(stop), .msg_len(msg_len),
        .busy(busy), .anode(anode), .segOut(segOut));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_buf [16];
    bit         m_run = 0;
    int         m_pos = 0, m_len = 0, m_rc = 0, m_sc = 0, m_d = 0;
    logic [3:0] e_anode = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_busy = 1'b0;
    bit         seg_care = 1;

    function automatic logic [6:0] glyph_of(int c);
        return (c < 17) ? GLYPH[c] : 7'h7F;
    endfunction

    function automatic int char_at(int k);
        if (m_len <= 4) return (k >= m_len) ? 31 : m_buf[k];
        return m_buf[(m_pos + k) % m_len];
    endfunction

    task automatic check(string tag, logic [6:0] obs, logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_pos = 0; m_len = 0; m_rc = 0; m_sc = 0; m_d = 0;
            e_anode = 4'hF; e_seg = 7'h7F; e_busy = 1'b0; seg_care = 1;
            return;
        end
        if (SWT) begin
            e_anode = 4'hF;
            e_anode[m_d] = 1'b0;
            e_seg = m_run ? glyph_of(char_at(3 - m_d)) : 7'h7F;
            seg_care = 1;
        end else begin
            e_anode = 4'hF;
            seg_care = 0;
        end
        if (wr_en) m_buf[wr_addr] = int'(wr_char);
        if (SWT) begin
            if (m_rc == RDIV - 1) begin
                m_rc = 0;
                m_d = (m_d + 3) % 4;
            end else m_rc++;
        end
        if (stop) m_run = 0;
        else if (start && msg_len != 0) begin
            m_run = 1; m_pos = 0; m_sc = 0;
            m_len = (msg_len > 16) ? 16 : int'(msg_len);
        end else if (m_run && SWT && m_len > 4) begin
            if (m_sc == SDIV - 1) begin
                m_sc = 0;
`ifdef SSD_SCROLL_DIR_EN
                if (dir) m_pos = (m_pos == 0) ? m_len - 1 : m_pos - 1;
                else     m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
`else
                m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
`endif
            end else m_sc++;
        end
        e_busy = m_run;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("anode", 7'(anode), 7'(e_anode));
        if (seg_care) check("segOut", segOut, e_seg);
        check("busy", 7'(busy), 7'(e_busy));
    endtask

    task automatic wr(int a, int c);
        wr_en = 1'b1; wr_addr = 4'(a); wr_char = 5'(c);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(int len);
        msg_len = 5'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; SWT = 1'b0; dir = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_char = '0; start = 1'b0; stop = 1'b0; msg_len = '0;
        tick(); tick();
        check("rst_anode", 7'(anode), 7'h0F);
        check("rst_seg", segOut, 7'h7F);
        check("rst_busy", 7'(busy), 7'h00);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, 31);

        // Idle refresh: anodes cycle, segments blank
        SWT = 1'b1;
        repeat (16) tick();

        // Short message "12": no scrolling
        wr(0, 1); wr(1, 2);
        go(2);
        check("short_busy", 7'(busy), 7'h01);
        repeat (200) tick();

        // Six-character message with wrap-around
        for (int i = 0; i < 6; i++) wr(i, i);
        go(6);
        repeat (7 * SDIV + 8) tick();

        // Simultaneous start/stop, then zero-length start
        start = 1'b1; stop = 1'b1; msg_len = 5'd6;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 7'(busy), 7'h00);
        go(0);
        tick();
        check("zero_len_busy", 7'(busy), 7'h00);

        // Display disable freezes refresh and scroll
        go(6);
        repeat (50) tick();
        SWT = 1'b0;
        tick();
        check("swt_off_anode", 7'(anode), 7'h0F);
        repeat (99) tick();
        SWT = 1'b1;
        repeat (100) tick();

        // Reset in the middle of scrolling
        rst = 1'b1;
        tick();
        check("midrst_anode", 7'(anode), 7'h0F);
        check("midrst_seg", segOut, 7'h7F);
        check("midrst_busy", 7'(busy), 7'h00);
        rst = 1'b0;

`ifdef SSD_SCROLL_DIR_EN
        dir = 1'b1;
        go(6);
        repeat (3 * SDIV + 8) tick();
        dir = 1'b0;
`endif

        // Random traffic
        go(9);
        for (int i = 0; i < 2000; i++) begin
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 4'($urandom);
            wr_char = 5'($urandom);
            start   = ($urandom % 150) == 0;
            msg_len = 5'($urandom_range(0, 20));
            stop    = ($urandom % 400) == 0;
            SWT     = ($urandom % 40) != 0;
            if (i % 100 == 0) dir = 1'($urandom);
            tick();
        end
        wr_en = 1'b0; start = 1'b0; stop = 1'b0; SWT = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
